// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store initiator: size codes, FSM encoding
// and the request alignment check.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // 1 when the access cannot be issued: illegal size or misaligned address
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return (lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian byte-lane steering: load extract/extend and sub-word store merge.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[31:24];
        case (lo)
            2'b00: byte_sel = word[31:24];
            2'b01: byte_sel = word[23:16];
            2'b10: byte_sel = word[15:8];
            2'b11: byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lo[1] ? word[15:0] : word[31:16];

        case (size)
            SZ_BYTE: rdata = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: rdata = word;
        endcase
    end

    always_comb begin
        merged = word;
        case (size)
            SZ_BYTE: begin
                case (lo)
                    2'b00: merged[31:24] = wdata[7:0];
                    2'b01: merged[23:16] = wdata[7:0];
                    2'b10: merged[15:8]  = wdata[7:0];
                    2'b11: merged[7:0]   = wdata[7:0];
                    default: merged = word;
                endcase
            end
            SZ_HALF: begin
                if (lo[1]) merged[15:0]  = wdata[15:0];
                else       merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, word-aligned memory cycles,
// read-modify-write for sub-word stores, registered response channel.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       write_data,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       read_data
);

    state_t      state, state_nxt;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lo;
    logic [31:0] r_wdata;
    logic [31:0] ld_data;
    logic [31:0] st_merged;
    logic        accept;
    logic        err_in;
    logic        word_store;

    assign accept     = req_valid && (state == ST_IDLE);
    assign err_in     = align_err(req_size, req_addr[1:0]);
    assign word_store = req_write && (req_size == SZ_WORD);

    mem_lane_align u_align (
        .word        (read_data),
        .lo          (r_lo),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .wdata       (r_wdata),
        .rdata       (ld_data),
        .merged      (st_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Strobes decode straight from state so reset drops MemWrite asynchronously
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (err_in)          state_nxt = ST_RESP;
                    else if (word_store) state_nxt = ST_WR;
                    else                 state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                MemRead   = 1'b1;
                state_nxt = r_write ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                MemWrite  = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write    <= 1'b0;
            r_size     <= SZ_BYTE;
            r_unsigned <= 1'b0;
            r_lo       <= 2'b00;
            r_wdata    <= '0;
            address    <= '0;
            write_data <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                r_write    <= req_write;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_lo       <= req_addr[1:0];
                r_wdata    <= req_wdata;
                address    <= {req_addr[ADDR_W-1:2], 2'b00};
                resp_err   <= err_in;
                resp_rdata <= '0;
                if (word_store && !err_in) write_data <= req_wdata;
            end
            // The read cycle feeds either the load result or the RMW write word
            if (state == ST_RD) begin
                if (r_write) write_data <= st_merged;
                else         resp_rdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] read_data;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [16] = '{1: 32'hDAFEEDBE, 2: 32'h12345678, 3: 32'h55667788, default: 32'h0};

    logic [31:0] o_rdata;
    logic        o_err;
    int          o_lat;
    logic [7:0]  o_rd;
    logic [7:0]  o_wr;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .address      (address),
        .write_data   (write_data),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data = mem[address[5:2]];
    always @(posedge clk) if (MemWrite) mem[address[5:2]] <= write_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, record strobes per cycle after the accepting edge,
    // capture the response, then complete the handshake.
    task automatic run(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        o_lat = 0; o_rd = '0; o_wr = '0; o_rdata = 32'hXXXXXXXX; o_err = 1'bx;
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            o_rd[c] = MemRead;
            o_wr[c] = MemWrite;
            if (resp_valid) begin
                o_lat = c; o_rdata = resp_rdata; o_err = resp_err;
                break;
            end
        end
        if (resp_valid) begin
            resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
        end
    endtask

    task automatic check_resp(input string tag, input logic [31:0] rdata, input logic err,
                              input int lat, input logic [7:0] rd, input logic [7:0] wr);
        check({tag, "_rdata"}, o_rdata, rdata);
        check({tag, "_err"}, {31'b0, o_err}, {31'b0, err});
        check({tag, "_lat"}, o_lat, lat);
        check({tag, "_memread"}, {24'b0, o_rd}, {24'b0, rd});
        check({tag, "_memwrite"}, {24'b0, o_wr}, {24'b0, wr});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_flags"}, {27'b0, req_ready, resp_valid, resp_err, MemRead, MemWrite},
              32'b10000);
        check({tag, "_rdata"}, resp_rdata, 32'h0);
        check({tag, "_address"}, address, 32'h0);
        check({tag, "_wdata"}, write_data, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Loads from 0x4 = 0xDAFEEDBE
        run(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check_resp("lw4", 32'hDAFEEDBE, 1'b0, 2, 8'h02, 8'h00);
        run(1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        check_resp("lb5", 32'hFFFFFFFE, 1'b0, 2, 8'h02, 8'h00);
        run(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        check_resp("lbu5", 32'h000000FE, 1'b0, 2, 8'h02, 8'h00);
        run(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        check_resp("lh6", 32'hFFFFEDBE, 1'b0, 2, 8'h02, 8'h00);
        run(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
        check_resp("lhu6", 32'h0000EDBE, 1'b0, 2, 8'h02, 8'h00);
        run(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
        check_resp("lb4", 32'hFFFFFFDA, 1'b0, 2, 8'h02, 8'h00);

        // Stores into 0x8 = 0x12345678
        run(1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AA);
        check_resp("sb9", 32'h0, 1'b0, 3, 8'h02, 8'h04);
        check("sb9_mem", mem[2], 32'h12AA5678);
        run(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000BEEF);
        check_resp("shA", 32'h0, 1'b0, 3, 8'h02, 8'h04);
        check("shA_mem", mem[2], 32'h12AABEEF);
        run(1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D);
        check_resp("sw8", 32'h0, 1'b0, 2, 8'h00, 8'h02);
        check("sw8_mem", mem[2], 32'hCAFEF00D);

        // Alignment errors and illegal size
        run(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        check_resp("lw6_err", 32'h0, 1'b1, 1, 8'h00, 8'h00);
        run(1'b1, 2'b01, 1'b0, 32'h9, 32'h1234);
        check_resp("sh9_err", 32'h0, 1'b1, 1, 8'h00, 8'h00);
        check("sh9_mem", mem[2], 32'hCAFEF00D);
        run(1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
        check_resp("sz11_err", 32'h0, 1'b1, 1, 8'h00, 8'h00);

        // Backpressure: response held, pending request ignored until handshake
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h4;
        req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk);
        #1 req_size = 2'b00; req_addr = 32'h5;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_c2", {31'b0, resp_valid}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_flags", {28'b0, resp_valid, resp_err, req_ready, MemRead}, 32'b1000);
            check("bp_hold_rdata", resp_rdata, 32'hDAFEEDBE);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_valid", {31'b0, resp_valid}, 32'h1);
        check("bp_next_rdata", resp_rdata, 32'hFFFFFFFE);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;

        // Reset during the WR cycle of sw 0xC
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'hC;
        req_wdata = 32'h0BADF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_wr_active", {31'b0, MemWrite}, 32'h1);
        #2 rst_n = 1'b0;
        #1 check("rst_memwrite_drop", {31'b0, MemWrite}, 32'h0);
        check_reset_outputs("rst_mid");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mem_unchanged", mem[3], 32'h55667788);
        run(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        check_resp("post_rst_lwC", 32'h55667788, 1'b0, 2, 8'h02, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
